// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: per-stage widths
// and the occupancy state encoding used by pipeline_stage_reg.
package mips_pipe_pkg;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 13;
  localparam int IDEX_DATA_W  = 143;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 71;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  // bit0 = main register full, bit1 = skid full
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry holding register with a valid bit; catches the beat that arrives
// while the main register is stalled.
module pipe_skid_buf #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Generic valid/ready pipeline stage register with bubble-on-empty control,
// hazard flush, optional skid buffer and a saturating stall counter.
module pipeline_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W  = 13,
  parameter int DATA_W  = 143,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BW = CTRL_W + DATA_W;

  pipe_state_e       r_state, w_nxt;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stall;

  logic          w_accept, w_emit;
  logic          w_load_in, w_load_skid, w_bubble;
  logic          w_skid_load, w_skid_pop, w_skid_vld;
  logic [BW-1:0] w_skid_q;

  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_emit    = out_valid & out_ready;

  generate
    if (SKID_EN) begin : g_skid
      pipe_skid_buf #(.W(BW)) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (flush),
        .i_load  (w_skid_load),
        .i_pop   (w_skid_pop),
        .i_data  ({in_ctrl, in_data}),
        .o_valid (w_skid_vld),
        .o_data  (w_skid_q)
      );
      assign in_ready = ~w_skid_vld;
    end else begin : g_noskid
      logic w_unused;
      assign w_skid_vld = 1'b0;
      assign w_skid_q   = '0;
      assign w_unused   = ^{w_skid_load, w_skid_pop, w_skid_vld};
      assign in_ready   = out_ready | ~out_valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_EMPTY;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (flush) begin
      w_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_nxt = ST_FULL;
        ST_FULL: begin
          // without a skid, accept while stalled cannot happen (in_ready=0)
          if (w_accept && !w_emit)      w_nxt = SKID_EN ? ST_SKID : ST_FULL;
          else if (!w_accept && w_emit) w_nxt = ST_EMPTY;
        end
        ST_SKID:  if (w_emit) w_nxt = ST_FULL;
        default:  w_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_load_in   = 1'b0;
    w_load_skid = 1'b0;
    w_bubble    = 1'b0;
    w_skid_load = 1'b0;
    w_skid_pop  = 1'b0;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_load_in = w_accept;
        ST_FULL: begin
          w_load_in   = w_accept & w_emit;
          w_skid_load = w_accept & ~w_emit;
          w_bubble    = ~w_accept & w_emit;
        end
        ST_SKID: begin
          w_load_skid = w_emit;
          w_skid_pop  = w_emit;
        end
        default: w_bubble = 1'b1;
      endcase
    end
  end

  // out_data deliberately survives bubbles and flushes; only ctrl is zeroed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (flush || w_bubble) begin
      r_ctrl <= '0;
    end else if (w_load_in) begin
      r_ctrl <= in_ctrl;
      r_data <= in_data;
    end else if (w_load_skid) begin
      {r_ctrl, r_data} <= w_skid_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall <= '0;
    else if (out_valid && !out_ready && !(&r_stall))
      r_stall <= r_stall + CNT_W'(1);
  end

  assign out_ctrl  = r_ctrl;
  assign out_data  = r_data;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Drives three stage registers (skid, skid with 4-bit counter, no skid) from
// one directed stimulus and checks them against an occupancy-queue model.
module tb_pipeline_stage_reg;

  localparam int ND = 3;

  typedef struct packed {
    logic [12:0]  c;
    logic [142:0] d;
  } beat_t;

  logic         clk, reset, flush, in_valid, out_ready;
  logic [12:0]  in_ctrl;
  logic [142:0] in_data;

  logic         ov [ND];
  logic         ir [ND];
  logic [12:0]  oc [ND];
  logic [142:0] od [ND];
  logic [15:0]  sc_a, sc_b;
  logic [3:0]   sc_c;

  int errors = 0;
  int checks = 0;

  pipeline_stage_reg #(.CTRL_W(13), .DATA_W(143), .SKID_EN(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]), .stall_cnt(sc_a));

  pipeline_stage_reg #(.CTRL_W(13), .DATA_W(143), .SKID_EN(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]), .stall_cnt(sc_b));

  pipeline_stage_reg #(.CTRL_W(13), .DATA_W(143), .SKID_EN(1'b1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_data(od[2]), .stall_cnt(sc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] get_sc(input int k);
    case (k)
      0:       return sc_a;
      1:       return sc_b;
      default: return {12'd0, sc_c};
    endcase
  endfunction

  // Model: each stage is a FIFO of at most 2 (skid) or 1 (no skid) beats
  localparam bit SKE  [ND] = '{1'b1, 1'b0, 1'b1};
  localparam int SMAX [ND] = '{65535, 65535, 15};
  beat_t        mq [ND][2];
  int           mn [ND];
  int           mstall [ND];
  logic [142:0] mlast [ND];
  logic         m_ir, m_emit, m_acc;

  initial begin
    for (int k = 0; k < ND; k++) begin
      mn[k] = 0; mstall[k] = 0; mlast[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        if (!reset) begin
          mn[k] = 0; mstall[k] = 0; mlast[k] = '0;
        end
        m_ir = SKE[k] ? (mn[k] < 2) : (out_ready || mn[k] == 0);
        chk($sformatf("dut%0d out_valid", k), 160'(ov[k]), 160'(mn[k] > 0));
        chk($sformatf("dut%0d in_ready", k), 160'(ir[k]), 160'(m_ir));
        chk($sformatf("dut%0d out_ctrl", k), 160'(oc[k]), (mn[k] > 0) ? 160'(mq[k][0].c) : 160'd0);
        chk($sformatf("dut%0d out_data", k), 160'(od[k]), 160'(mlast[k]));
        chk($sformatf("dut%0d stall_cnt", k), 160'(get_sc(k)), 160'(mstall[k]));
        if (reset) begin
          if (mn[k] > 0 && !out_ready && mstall[k] < SMAX[k]) mstall[k]++;
          if (flush) begin
            mn[k] = 0;
          end else begin
            m_emit = (mn[k] > 0) && out_ready;
            m_acc  = in_valid && m_ir;
            if (m_emit) begin
              mq[k][0] = mq[k][1];
              mn[k]--;
            end
            if (m_acc) begin
              mq[k][mn[k]] = '{c: in_ctrl, d: in_data};
              mn[k]++;
            end
          end
          if (mn[k] > 0) mlast[k] = mq[k][0].d;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [12:0] c, input logic [142:0] d,
                     input logic rdy, input logic fl);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = rdy; flush = fl;
    @(posedge clk); #1;
  endtask

  int nemit;

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    #2;
    chk("reset out_valid", 160'(ov[0]), 160'd0);
    chk("reset out_ctrl",  160'(oc[0]), 160'd0);
    chk("reset out_data",  160'(od[0]), 160'd0);
    chk("reset stall_cnt", 160'(sc_a),  160'd0);
    chk("reset in_ready",  160'(ir[0]), 160'd1);
    @(posedge clk); #1;
    cyc(0, 0, 0, 1, 0);
    reset = 1'b1;

    // single beat, 1-cycle latency
    cyc(1, 13'h1A5, 143'h1234, 1, 0);
    chk("t1 out_valid", 160'(ov[0]), 160'd1);
    chk("t1 out_ctrl",  160'(oc[0]), 160'h1A5);
    chk("t1 out_data",  160'(od[0]), 160'h1234);
    chk("t1 in_ready",  160'(ir[0]), 160'd1);
    cyc(0, 0, 0, 1, 0);
    chk("t1 bubble ctrl", 160'(oc[0]), 160'd0);
    chk("t1 data holds",  160'(od[0]), 160'h1234);

    // stream with a 3-cycle stall after beat 2
    cyc(1, 13'd1, 143'h101, 1, 0);
    cyc(1, 13'd2, 143'h102, 1, 0);
    cyc(1, 13'd3, 143'h103, 0, 0);
    chk("t2 skid full in_ready", 160'(ir[0]), 160'd0);
    cyc(1, 13'd4, 143'h104, 0, 0);
    cyc(1, 13'd4, 143'h104, 0, 0);
    chk("t2 stall_cnt",  160'(sc_a),  160'd3);
    chk("t2 held ctrl",  160'(oc[0]), 160'd2);
    cyc(1, 13'd4, 143'h104, 1, 0);
    chk("t2 beat3 ctrl", 160'(oc[0]), 160'd3);
    chk("t2 in_ready back", 160'(ir[0]), 160'd1);
    cyc(1, 13'd4, 143'h104, 1, 0);
    chk("t2 beat4 ctrl", 160'(oc[0]), 160'd4);
    cyc(0, 0, 0, 1, 0);
    chk("t2 drained", 160'(ov[0]), 160'd0);

    // flush with main and skid full and a beat offered
    cyc(1, 13'h11, 143'hC1, 0, 0);
    cyc(1, 13'h12, 143'hC2, 0, 0);
    chk("t3 skid full", 160'(ir[0]), 160'd0);
    cyc(1, 13'h13, 143'hC3, 0, 1);
    chk("t3 out_valid", 160'(ov[0]), 160'd0);
    chk("t3 out_ctrl",  160'(oc[0]), 160'd0);
    chk("t3 in_ready",  160'(ir[0]), 160'd1);
    chk("t3 data kept", 160'(od[0]), 160'hC1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t3 no ghost beat", 160'(ov[0]), 160'd0);
    chk("t3 stall kept",    160'(sc_a),  160'd5);

    // asynchronous reset between edges
    cyc(1, 13'h21, 143'hD1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("t4 async out_valid", 160'(ov[0]), 160'd0);
    chk("t4 async out_ctrl",  160'(oc[0]), 160'd0);
    chk("t4 async out_data",  160'(od[0]), 160'd0);
    chk("t4 async stall_cnt", 160'(sc_a),  160'd0);
    chk("t4 async in_ready",  160'(ir[0]), 160'd1);
    @(posedge clk); #1;
    cyc(0, 0, 0, 1, 0);
    reset = 1'b1;

    // 20 stall cycles: 4-bit counter saturates
    cyc(1, 13'h31, 143'hE1, 1, 0);
    repeat (20) cyc(0, 0, 0, 0, 0);
    chk("t5 sat 4-bit", 160'(sc_c), 160'd15);
    chk("t5 16-bit",    160'(sc_a), 160'd20);

    // no-skid stage: in_ready follows out_ready combinationally
    cyc(0, 0, 0, 1, 0);
    nemit = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_ctrl = 13'(16'h40 + i); in_data = 143'(32'hF00 + i);
      out_ready = (i % 2) == 1;
      #1;
      if (i > 0) chk($sformatf("t6 in_ready c%0d", i), 160'(ir[1]), 160'(out_ready));
      if (ov[1] && out_ready) nemit++;
      @(posedge clk); #1;
    end
    chk("t6 emits", 160'(nemit), 160'd4);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
